// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        HUNT, GET_CMD, GET_DATA, GET_CHK, EXEC, RD_WAIT, RESP
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    // 8-bit wrapping checksum over SYNC, CMD and DATA
    function automatic logic [7:0] frame_sum(input logic [7:0] cmd, input logic [7:0] data);
        return SYNC_BYTE + cmd + data;
    endfunction

endpackage

// File: rtl/rx_byte_take.sv
// Byte capture over the uart_rx valid/ack_n handshake; one strobe per accepted byte.
module rx_byte_take (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ack_n,
    output logic [7:0] rx_byte,
    output logic       strobe
);

    logic pend;

    // pend masks a valid held one cycle past the ack so a byte is never taken twice
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ack_n <= 1'b1;
            rx_byte  <= '0;
            strobe   <= 1'b0;
            pend     <= 1'b0;
        end else begin
            rx_ack_n <= 1'b1;
            strobe   <= 1'b0;
            if (en && rx_valid && !pend) begin
                rx_byte  <= rx_data;
                rx_ack_n <= 1'b0;
                strobe   <= 1'b1;
                pend     <= 1'b1;
            end else if (!rx_valid) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frames 4-byte UART commands, runs one register access per frame and queues a 1-byte reply.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT = 100000,
    parameter int RD_LAT  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ack_n,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] err_cnt,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t          state;
    logic [7:0]      cmd, dat, rx_byte;
    logic            strobe, take_en, in_get, tmo_hit, chk_bad, err_inc;
    logic [TW-1:0]   tmo;
    logic [RW-1:0]   rd_cnt;

    assign in_get  = state inside {GET_CMD, GET_DATA, GET_CHK};
    // Holding off while a strobe is in flight keeps the take aligned to the FSM step
    assign take_en = (state == HUNT || in_get) && !strobe;
    assign tmo_hit = in_get && (tmo == '0) && !strobe;
    assign chk_bad = (state == GET_CHK) && strobe && (rx_byte != frame_sum(cmd, dat));
    assign err_inc = tmo_hit || chk_bad;
    assign busy    = (state != HUNT);

    rx_byte_take u_take (
        .clk      (clk),
        .rst      (rst),
        .en       (take_en),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ack_n (rx_ack_n),
        .rx_byte  (rx_byte),
        .strobe   (strobe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo     <= '0;
            err_cnt <= '0;
        end else begin
            if (strobe)
                tmo <= TW'(TIMEOUT);
            else if (in_get && tmo != '0)
                tmo <= tmo - TW'(1);
            if (err_inc && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            cmd       <= '0;
            dat       <= '0;
            rd_cnt    <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            if (tmo_hit) begin
                state <= HUNT;
            end else begin
                case (state)
                    HUNT:     if (strobe && rx_byte == SYNC_BYTE) state <= GET_CMD;
                    GET_CMD:  if (strobe) begin cmd <= rx_byte; state <= GET_DATA; end
                    GET_DATA: if (strobe) begin dat <= rx_byte; state <= GET_CHK;  end
                    GET_CHK: if (strobe) begin
                        if (chk_bad) begin
                            tx_data  <= NAK_BYTE;
                            tx_valid <= 1'b1;
                            state    <= RESP;
                        end else begin
                            // strobes are registered here so they are high during EXEC
                            reg_addr <= cmd[6:0];
                            reg_we   <= cmd[7];
                            reg_re   <= !cmd[7];
                            if (cmd[7]) reg_wdata <= dat;
                            state    <= EXEC;
                        end
                    end
                    EXEC: begin
                        if (cmd[7]) begin
                            tx_data  <= ACK_BYTE;
                            tx_valid <= 1'b1;
                            state    <= RESP;
                        end else begin
                            rd_cnt <= RW'(RD_LAT - 1);
                            state  <= RD_WAIT;
                        end
                    end
                    RD_WAIT: begin
                        if (rd_cnt == '0) begin
                            tx_data  <= reg_rdata;
                            tx_valid <= 1'b1;
                            state    <= RESP;
                        end else begin
                            rd_cnt <= rd_cnt - RW'(1);
                        end
                    end
                    RESP: if (tx_ready) begin tx_valid <= 1'b0; state <= HUNT; end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench: directed and random frames against a frame-level reference model.
module tb_uart_cmd_ctrl;

    localparam int TIMEOUT = 40;
    localparam int RD_LAT  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_ack_n;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we, reg_re;
    logic [7:0] reg_rdata;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [7:0] err_cnt;
    logic       busy;

    int compared = 0, mismatched = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_cmd_ctrl #(.TIMEOUT(TIMEOUT), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack_n(rx_ack_n),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .err_cnt(err_cnt), .busy(busy)
    );

    // Register-bus environment: unwritten registers read back as a fixed pattern
    function automatic logic [7:0] dflt(input logic [6:0] a);
        return {1'b0, a} ^ 8'h2E;
    endfunction

    logic [7:0] bus_mem [128];
    bit         bus_vld [128];
    logic [1:0] re_sh = '0;
    logic [6:0] a_sh0 = '0, a_sh1 = '0;

    always @(posedge clk) begin
        re_sh <= {re_sh[0], reg_re};
        a_sh0 <= reg_addr;
        a_sh1 <= a_sh0;
    end
    assign reg_rdata = re_sh[1] ? (bus_vld[a_sh1] ? bus_mem[a_sh1] : dflt(a_sh1)) : 8'hEE;

    int         we_tot = 0, re_tot = 0, resp_tot = 0;
    int         we_cyc = 0, re_cyc = 0, txv_cyc = 0;
    logic [6:0] we_addr = '0, re_addr = '0;
    logic [7:0] we_data = '0, last_resp = '0;
    logic       txv_prev = 1'b0;

    always @(negedge clk) begin
        if (reg_we) begin
            we_tot <= we_tot + 1; we_cyc <= cyc; we_addr <= reg_addr; we_data <= reg_wdata;
            bus_mem[reg_addr] <= reg_wdata; bus_vld[reg_addr] <= 1'b1;
        end
        if (reg_re) begin
            re_tot <= re_tot + 1; re_cyc <= cyc; re_addr <= reg_addr;
        end
        txv_prev <= tx_valid;
        if (tx_valid && !txv_prev) txv_cyc <= cyc;
        if (tx_valid && tx_ready) begin
            resp_tot <= resp_tot + 1; last_resp <= tx_data;
        end
    end

    // Reference model: register contents as commanded by good write frames, plus error count
    logic [7:0] ref_mem [128];
    bit         ref_vld [128];
    int         m_err = 0;

    function automatic logic [7:0] sum_of(input logic [7:0] c, input logic [7:0] d);
        int s;
        s = (165 + int'(c) + int'(d)) % 256;
        return s[7:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int ackc);
        bit got;
        got  = 1'b0;
        ackc = -1;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!rx_ack_n) begin got = 1'b1; ackc = cyc; break; end
        end
        check("byte_ack", 64'(got), 64'd1);
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
        int         ackc, bw, br, bresp;
        bit         good, wr;
        logic [6:0] a;
        logic [7:0] exp;
        good  = (sum_of(c, d) == k);
        wr    = c[7];
        a     = c[6:0];
        bw    = we_tot; br = re_tot; bresp = resp_tot;
        send_byte(8'hA5, ackc);
        send_byte(c, ackc);
        send_byte(d, ackc);
        send_byte(k, ackc);
        for (int i = 0; i < 60 && resp_tot == bresp; i++) begin @(posedge clk); #1; end
        check("resp_count", 64'(resp_tot - bresp), 64'd1);
        exp = !good ? 8'h15 : wr ? 8'h06 : (ref_vld[a] ? ref_mem[a] : dflt(a));
        check("resp_byte", 64'(last_resp), 64'(exp));
        check("we_count", 64'(we_tot - bw), 64'(good && wr));
        check("re_count", 64'(re_tot - br), 64'(good && !wr));
        if (good && wr) begin
            check("we_addr", 64'(we_addr), 64'(a));
            check("we_data", 64'(we_data), 64'(d));
            check("we_lat", 64'(we_cyc - ackc), 64'd1);
            check("wr_resp_lat", 64'(txv_cyc - ackc), 64'd2);
            ref_mem[a] = d;
            ref_vld[a] = 1'b1;
        end
        if (good && !wr) begin
            check("re_addr", 64'(re_addr), 64'(a));
            check("re_lat", 64'(re_cyc - ackc), 64'd1);
            check("rd_resp_lat", 64'(txv_cyc - ackc), 64'(RD_LAT + 2));
        end
        if (!good && m_err < 255) m_err++;
        check("err_cnt", 64'(err_cnt), 64'(m_err));
        check("idle_after", 64'({busy, tx_valid}), 64'd0);
    endtask

    initial begin
        int         ackc, bw, bresp, bad;
        bit         got;
        logic [7:0] c, d, k;

        #1 rst = 1'b1;
        #1;
        check("reset_vals", 64'({rx_ack_n, reg_addr, reg_wdata, reg_we, reg_re, tx_data, tx_valid, err_cnt, busy}),
              {28'd0, 1'b1, 35'd0});
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // write; A5+83+5A wraps to 82
        do_frame(8'h83, 8'h5A, 8'h82);
        do_frame(8'h12, 8'h00, 8'hB7);
        do_frame(8'h83, 8'h5A, 8'h00);
        do_frame(8'h03, 8'h00, sum_of(8'h03, 8'h00));

        send_byte(8'h00, ackc);
        send_byte(8'hFF, ackc);
        send_byte(8'h55, ackc);
        check("garbage_err", 64'(err_cnt), 64'(m_err));
        check("garbage_idle", 64'(busy), 64'd0);
        do_frame(8'h84, 8'hC3, sum_of(8'h84, 8'hC3));

        // partial frame then silence
        bw = we_tot; bresp = resp_tot;
        send_byte(8'hA5, ackc);
        send_byte(8'h83, ackc);
        repeat (TIMEOUT - 10) @(posedge clk);
        #1 check("tmo_still_busy", 64'(busy), 64'd1);
        repeat (15) @(posedge clk);
        #1;
        m_err++;
        check("tmo_idle", 64'(busy), 64'd0);
        check("tmo_err", 64'(err_cnt), 64'(m_err));
        check("tmo_no_resp", 64'(resp_tot - bresp), 64'd0);
        check("tmo_no_we", 64'(we_tot - bw), 64'd0);
        do_frame(8'h04, 8'h00, sum_of(8'h04, 8'h00));

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 164)), ackc);
            c = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7))};
            d = 8'($urandom);
            k = sum_of(c, d);
            if ($urandom_range(0, 3) == 0) k = k ^ 8'($urandom_range(1, 255));
            do_frame(c, d, k);
        end

        for (int n = 0; n < 260; n++) begin
            c = 8'($urandom);
            d = 8'($urandom);
            do_frame(c, d, sum_of(c, d) ^ 8'h5A);
        end

        // response stalled while the next SYNC waits on rx_valid
        @(posedge clk); #1 tx_ready = 1'b0;
        bresp = resp_tot;
        send_byte(8'hA5, ackc);
        send_byte(8'h85, ackc);
        send_byte(8'h77, ackc);
        send_byte(sum_of(8'h85, 8'h77), ackc);
        for (int i = 0; i < 20 && !tx_valid; i++) begin @(posedge clk); #1; end
        check("stall_txv", 64'(tx_valid), 64'd1);
        @(negedge clk);
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (tx_data !== 8'h06 || rx_ack_n !== 1'b1 || tx_valid !== 1'b1) bad++;
        end
        check("stall_hold", 64'(bad), 64'd0);
        check("stall_no_resp", 64'(resp_tot - bresp), 64'd0);
        tx_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!rx_ack_n) begin got = 1'b1; break; end
        end
        check("post_stall_ack", 64'(got), 64'd1);
        check("post_stall_resp", 64'(resp_tot - bresp), 64'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        ref_mem[7'h05] = 8'h77;
        ref_vld[7'h05] = 1'b1;

        send_byte(8'h83, ackc);
        bw = we_tot; bresp = resp_tot;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midframe_reset", 64'({rx_ack_n, reg_addr, reg_wdata, reg_we, reg_re, tx_data, tx_valid, err_cnt, busy}),
              {28'd0, 1'b1, 35'd0});
        m_err = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_no_we", 64'(we_tot - bw), 64'd0);
        check("reset_no_resp", 64'(resp_tot - bresp), 64'd0);
        do_frame(8'h05, 8'h00, sum_of(8'h05, 8'h00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
